universal_register: RTL

Parametrised multi-mode register for the sc_microprocessor datapath. It generalises the single-bit gated D flip-flop into a WIDTH-bit register with several modes: hold, parallel load, logical shift, rotate, increment and decrement. It also produces a registered carry-out flag and a zero flag. It serves as the building block for the program counter, shift/accumulator registers and loop counters.

---
 rtl/universal_register.sv | 55 +++++
 1 files changed

// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with hold/load/shift/rotate/inc/dec modes, carry and zero flags
module universal_register #(
  parameter int WIDTH = 8,
  parameter logic [31:0] RESET_VAL = 32'd0,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero
);
  logic [WIDTH-1:0] q_nx;
  logic             c_nx;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             ones;
  assign sum  = {1'b0, q} + 1'b1;
  assign diff = {1'b0, q} - 1'b1;
  assign ones = &q;
  assign zero = ~|q;
  // d and sin are only referenced by the modes that consume them
  always_comb begin
    q_nx = q;
    c_nx = cout;
    case (mode)
      3'b001: begin q_nx = d; c_nx = 1'b0; end
      3'b010: begin q_nx = {q[WIDTH-2:0], sin}; c_nx = q[WIDTH-1]; end
      3'b011: begin q_nx = {sin, q[WIDTH-1:1]}; c_nx = q[0]; end
      3'b100: begin q_nx = {q[WIDTH-2:0], q[WIDTH-1]}; c_nx = q[WIDTH-1]; end
      3'b101: begin q_nx = {q[0], q[WIDTH-1:1]}; c_nx = q[0]; end
      3'b110: begin
        q_nx = (SATURATE && ones) ? q : sum[WIDTH-1:0];
        c_nx = sum[WIDTH];
      end
      3'b111: begin
        q_nx = (SATURATE && zero) ? q : diff[WIDTH-1:0];
        c_nx = diff[WIDTH];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      q    <= RESET_VAL[WIDTH-1:0];
      cout <= 1'b0;
    end else if (en) begin
      q    <= q_nx;
      cout <= c_nx;
    end
endmodule
